// File: rtl/prga.sv
// rtl/prga.sv - ARC4 pseudo-random generation stage: decrypts length-prefixed CT into PT using S.
// Optional keystream tap ports ks_byte/ks_valid enabled by `define PRGA_KS_OUT_EN.
module prga #(
  parameter int MAX_LEN = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
`ifdef PRGA_KS_OUT_EN
  ,
  output logic [7:0] ks_byte,
  output logic       ks_valid
`endif
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [4:0] {
    IDLE,
    RD_LEN,
    WAIT_LEN,
    CAP_LEN,
    WR_LEN,
    RD_SI,
    WAIT_SI,
    CAP_SI,
    RD_SJ,
    WAIT_SJ,
    CAP_SJ,
    WR_SI,
    WR_SJ,
    RD_PAD,
    WAIT_PAD,
    CAP_PAD,
    WR_PT,
    DONE
  } state_t;

  state_t state, state_next;

  logic [7:0] i, j, len, si, sj, pad, ctb;
  logic [8:0] k;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (en) state_next = RD_LEN;
      RD_LEN:   state_next = WAIT_LEN;
      WAIT_LEN: state_next = CAP_LEN;
      CAP_LEN:  state_next = WR_LEN;
      WR_LEN:   state_next = (len == 8'd0) ? DONE : RD_SI;
      RD_SI:    state_next = WAIT_SI;
      WAIT_SI:  state_next = CAP_SI;
      CAP_SI:   state_next = RD_SJ;
      RD_SJ:    state_next = WAIT_SJ;
      WAIT_SJ:  state_next = CAP_SJ;
      CAP_SJ:   state_next = WR_SI;
      WR_SI:    state_next = WR_SJ;
      WR_SJ:    state_next = RD_PAD;
      RD_PAD:   state_next = WAIT_PAD;
      WAIT_PAD: state_next = CAP_PAD;
      CAP_PAD:  state_next = WR_PT;
      WR_PT:    state_next = (k == {1'b0, len}) ? DONE : RD_SI;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Every output is a register loaded from the state being left, so it shows up one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy       <= 1'b1;
      s_addr    <= 8'd0;
      s_wrdata  <= 8'd0;
      s_wren    <= 1'b0;
      ct_addr   <= 8'd0;
      pt_addr   <= 8'd0;
      pt_wrdata <= 8'd0;
      pt_wren   <= 1'b0;
      i         <= 8'd0;
      j         <= 8'd0;
      k         <= 9'd0;
      len       <= 8'd0;
      si        <= 8'd0;
      sj        <= 8'd0;
      pad       <= 8'd0;
      ctb       <= 8'd0;
`ifdef PRGA_KS_OUT_EN
      ks_byte   <= 8'd0;
      ks_valid  <= 1'b0;
`endif
    end else begin
      s_wren  <= 1'b0;
      pt_wren <= 1'b0;
`ifdef PRGA_KS_OUT_EN
      ks_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (en) rdy <= 1'b0;
        end
        RD_LEN: begin
          ct_addr <= 8'd0;
        end
        CAP_LEN: begin
          len <= (ct_rddata > MAX_LEN_B) ? MAX_LEN_B : ct_rddata;
          i   <= 8'd0;
          j   <= 8'd0;
          k   <= 9'd1;
        end
        WR_LEN: begin
          pt_addr   <= 8'd0;
          pt_wrdata <= len;
          pt_wren   <= 1'b1;
        end
        RD_SI: begin
          i      <= i + 8'd1;
          s_addr <= i + 8'd1;
        end
        CAP_SI: begin
          si <= s_rddata;
          j  <= j + s_rddata;
        end
        RD_SJ: begin
          s_addr <= j;
        end
        CAP_SJ: begin
          sj <= s_rddata;
        end
        // When i==j the WR_SJ write lands last and leaves si in place, as ARC4 requires.
        WR_SI: begin
          s_addr   <= i;
          s_wrdata <= sj;
          s_wren   <= 1'b1;
        end
        WR_SJ: begin
          s_addr   <= j;
          s_wrdata <= si;
          s_wren   <= 1'b1;
        end
        RD_PAD: begin
          s_addr  <= si + sj;
          ct_addr <= k[7:0];
        end
        CAP_PAD: begin
          pad <= s_rddata;
          ctb <= ct_rddata;
        end
        WR_PT: begin
          pt_addr   <= k[7:0];
          pt_wrdata <= pad ^ ctb;
          pt_wren   <= 1'b1;
          if (k != {1'b0, len}) k <= k + 9'd1;
`ifdef PRGA_KS_OUT_EN
          ks_byte  <= pad;
          ks_valid <= 1'b1;
`endif
        end
        DONE: begin
          rdy <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prga.sv
// tb/tb_prga.sv - directed self-checking bench for prga with synchronous S/CT/PT memory models.
module tb_prga;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr, ct_rddata;
  logic [7:0] pt_addr, pt_wrdata;
  logic       pt_wren;
`ifdef PRGA_KS_OUT_EN
  logic [7:0] ks_byte;
  logic       ks_valid;
`endif

  prga dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .s_addr    (s_addr),
    .s_rddata  (s_rddata),
    .s_wrdata  (s_wrdata),
    .s_wren    (s_wren),
    .ct_addr   (ct_addr),
    .ct_rddata (ct_rddata),
    .pt_addr   (pt_addr),
    .pt_wrdata (pt_wrdata),
    .pt_wren   (pt_wren)
`ifdef PRGA_KS_OUT_EN
    ,
    .ks_byte   (ks_byte),
    .ks_valid  (ks_valid)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] s_mem  [256];
  logic [7:0] s_init [256];
  logic [7:0] ct_mem [256];
  logic [7:0] pt_mem [256];
  logic [7:0] gs     [256];
  logic [7:0] exp_pt [256];
  logic       load_s = 1'b0;
  logic       clr_pt = 1'b0;
  int         s_wr_total = 0;
  int         pt_wr_total = 0;
  int         tests = 0;
  int         fails = 0;

  always @(posedge clk) begin
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
    if (load_s) begin
      for (int x = 0; x < 256; x++) s_mem[x] <= s_init[x];
    end else if (s_wren) begin
      s_mem[s_addr] <= s_wrdata;
    end
    if (clr_pt) begin
      for (int x = 0; x < 256; x++) pt_mem[x] <= 8'hEE;
    end else if (pt_wren) begin
      pt_mem[pt_addr] <= pt_wrdata;
    end
    if (s_wren)  s_wr_total  <= s_wr_total + 1;
    if (pt_wren) pt_wr_total <= pt_wr_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic prep();
    load_s = 1'b1;
    clr_pt = 1'b1;
    @(posedge clk); #1;
    load_s = 1'b0;
    clr_pt = 1'b0;
  endtask

  task automatic set_identity();
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
  endtask

  task automatic set_ct(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    for (int x = 0; x < 256; x++) ct_mem[x] = 8'h00;
    ct_mem[0] = b0;
    ct_mem[1] = b1;
    ct_mem[2] = b2;
  endtask

  // Counts edges from the accepting edge until rdy returns; en is pulsed once at pulse_at.
  task automatic run(input int pulse_at, output int edges);
    en = 1'b1;
    @(posedge clk); #1;
    check("accept_rdy_low", {31'd0, rdy}, 32'd0);
    en = 1'b0;
    edges = 0;
    while (rdy !== 1'b1 && edges < 4000) begin
      en = (edges == pulse_at);
      @(posedge clk); #1;
      edges++;
    end
    en = 1'b0;
    if (edges >= 4000) check("run_timeout", {31'd0, rdy}, 32'd1);
  endtask

  task automatic wait_rdy(output int edges);
    edges = 0;
    while (rdy !== 1'b1 && edges < 4000) begin
      @(posedge clk); #1;
      edges++;
    end
    if (edges >= 4000) check("wait_timeout", {31'd0, rdy}, 32'd1);
  endtask

  task automatic golden_ksa();
    logic [7:0] kb [3];
    logic [7:0] gj, t;
    kb[0] = 8'h00;
    kb[1] = 8'h00;
    kb[2] = 8'h18;
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    gj = 8'd0;
    for (int x = 0; x < 256; x++) begin
      gj = gj + s_init[x] + kb[x % 3];
      t = s_init[x];
      s_init[x] = s_init[gj];
      s_init[gj] = t;
    end
  endtask

  task automatic golden_prga(input int len);
    logic [7:0] gi, gj, t;
    for (int x = 0; x < 256; x++) gs[x] = s_init[x];
    exp_pt[0] = 8'(len);
    gi = 8'd0;
    gj = 8'd0;
    for (int x = 1; x <= len; x++) begin
      gi = gi + 8'd1;
      gj = gj + gs[gi];
      t = gs[gi];
      gs[gi] = gs[gj];
      gs[gj] = t;
      t = gs[gi] + gs[gj];
      exp_pt[x] = ct_mem[x] ^ gs[t];
    end
  endtask

  initial begin
    int n, n2, s0, p0;
    rst_n = 1'b0;
    en = 1'b0;
    set_identity();
    set_ct(8'h00, 8'h00, 8'h00);
    @(posedge clk); #1;
    check("rst_rdy", {31'd0, rdy}, 32'd1);
    check("rst_s_wren", {31'd0, s_wren}, 32'd0);
    check("rst_pt_wren", {31'd0, pt_wren}, 32'd0);
    check("rst_addrs", {8'd0, s_addr, ct_addr, pt_addr}, 32'd0);
    check("rst_wrdata", {16'd0, s_wrdata, pt_wrdata}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // One-byte message over identity S: i=j=1, pad=S[2].
    set_identity();
    set_ct(8'd1, 8'h00, 8'h00);
    prep();
    s0 = s_wr_total; p0 = pt_wr_total;
    run(-1, n);
    check("len1_cycles", n, 17);
    check("len1_pt0", pt_mem[0], 8'h01);
    check("len1_pt1", pt_mem[1], 8'h02);
    check("len1_s_writes", s_wr_total - s0, 2);
    check("len1_pt_writes", pt_wr_total - p0, 2);
`ifdef PRGA_KS_OUT_EN
    check("len1_ks_byte", ks_byte, 8'h02);
`endif

    // Two-byte message, with a stray en pulse mid-run.
    set_identity();
    set_ct(8'd2, 8'h00, 8'hFF);
    prep();
    run(10, n);
    check("len2_cycles", n, 29);
    check("len2_pt0", pt_mem[0], 8'h02);
    check("len2_pt1", pt_mem[1], 8'h02);
    check("len2_pt2", pt_mem[2], 8'hFA);
    check("len2_s1", s_mem[1], 8'h01);
    check("len2_s2", s_mem[2], 8'h03);
    check("len2_s3", s_mem[3], 8'h02);
    check("len2_s5", s_mem[5], 8'h05);

    // Zero-length message: only the length byte is written.
    set_identity();
    set_ct(8'd0, 8'h55, 8'h66);
    prep();
    s0 = s_wr_total; p0 = pt_wr_total;
    run(-1, n);
    check("len0_cycles", n, 5);
    check("len0_pt0", pt_mem[0], 8'h00);
    check("len0_pt_writes", pt_wr_total - p0, 1);
    check("len0_s_writes", s_wr_total - s0, 0);

    // Full 255-byte message over the S produced by key 24'h000018.
    golden_ksa();
    for (int x = 1; x < 256; x++) ct_mem[x] = 8'($urandom_range(0, 255));
    ct_mem[0] = 8'd255;
    golden_prga(255);
    prep();
    p0 = pt_wr_total;
    run(-1, n);
    check("len255_cycles", n, 3065);
    check("len255_pt_writes", pt_wr_total - p0, 256);
    for (int x = 0; x < 256; x++) check($sformatf("len255_pt%0d", x), pt_mem[x], exp_pt[x]);

    // Reset while WR_SI of byte 3 is active, then a clean rerun.
    set_identity();
    set_ct(8'd5, 8'h11, 8'h22);
    prep();
    p0 = pt_wr_total;
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    for (int e = 0; e < 34; e++) begin
      @(posedge clk); #1;
    end
    check("midrst_busy", {31'd0, rdy}, 32'd0);
    check("midrst_pt_so_far", pt_wr_total - p0, 3);
    rst_n = 1'b0;
    #1;
    check("midrst_rdy", {31'd0, rdy}, 32'd1);
    check("midrst_s_wren", {31'd0, s_wren}, 32'd0);
    check("midrst_pt_wren", {31'd0, pt_wren}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_identity();
    set_ct(8'd2, 8'h00, 8'hFF);
    prep();
    run(-1, n);
    check("rerun_cycles", n, 29);
    check("rerun_pt0", pt_mem[0], 8'h02);
    check("rerun_pt2", pt_mem[2], 8'hFA);

    // en held high across DONE starts the next run on the IDLE edge.
    set_identity();
    set_ct(8'd1, 8'h00, 8'h00);
    prep();
    p0 = pt_wr_total;
    en = 1'b1;
    @(posedge clk); #1;
    check("hold_accept", {31'd0, rdy}, 32'd0);
    wait_rdy(n);
    check("hold_first_cycles", n, 17);
    @(posedge clk); #1;
    check("hold_restart", {31'd0, rdy}, 32'd0);
    en = 1'b0;
    wait_rdy(n2);
    check("hold_second_cycles", n2, 17);
    check("hold_pt_writes", pt_wr_total - p0, 4);
    check("hold_pt1", pt_mem[1], 8'h02);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
